// File: rtl/mips_pkg.sv
// Shared widths and encodings for the fetch/data memory arbiter.
// The FSM only ever distinguishes "free to arbitrate" from "access in flight".
package mips_pkg;

  localparam int DW_DEF = 32;
  localparam int AW_DEF = 10;
  localparam int CNT_W  = 4;

  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_ACCESS = 1'b1
  } state_t;

  typedef enum logic {
    SEL_IF = 1'b0,
    SEL_DM = 1'b1
  } sel_t;

endpackage

// File: rtl/mips_starve_ctr.sv
// Counts consecutive data wins taken while a fetch was waiting; force_if tells the
// arbiter the fetch side must win the next contested slot.
module mips_starve_ctr
  import mips_pkg::*;
#(
  parameter int MAX_STARVE = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic inc,
  input  logic clr,
  output logic force_if
);

  localparam logic [CNT_W-1:0] MAX_C = CNT_W'(MAX_STARVE);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (inc && (cnt_q != MAX_C)) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign force_if = (cnt_q == MAX_C);

endmodule

// File: rtl/mips_mem_arbiter.sv
// Serialises IF fetches and MEM loads/stores onto one memory with a fixed read latency.
// rst_n is expected to arrive with its release already synchronised to clk.
module mips_mem_arbiter
  import mips_pkg::*;
#(
  parameter int DW         = DW_DEF,
  parameter int AW         = AW_DEF,
  parameter int LAT        = 1,
  parameter int MAX_STARVE = 2
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          halted,
  input  logic          if_req,
  input  logic [AW-1:0] if_addr,
  output logic          if_gnt,
  output logic          if_rvalid,
  output logic [DW-1:0] if_rdata,
  input  logic          dm_req,
  input  logic          dm_we,
  input  logic [AW-1:0] dm_addr,
  input  logic [DW-1:0] dm_wdata,
  output logic          dm_gnt,
  output logic          dm_rvalid,
  output logic [DW-1:0] dm_rdata,
  output logic          mem_en,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata,
  output logic          stall_if,
  output logic          stall_mem
);

  localparam logic [CNT_W-1:0] LAT_C = CNT_W'(LAT);

  state_t           state_q, state_d;
  sel_t             sel_q, sel_d;
  logic [CNT_W-1:0] lat_q, lat_d;
  logic             gnt_q, gnt_d;
  logic             mem_en_q, mem_en_d;
  logic             mem_we_q, mem_we_d;
  logic             acc_we_q, acc_we_d;
  logic             rvalid_q, rvalid_d;
  logic [AW-1:0]    mem_addr_q, mem_addr_d;
  logic [DW-1:0]    mem_wdata_q, mem_wdata_d;
  logic [DW-1:0]    if_rdata_q, if_rdata_d;
  logic [DW-1:0]    dm_rdata_q, dm_rdata_d;

  logic elig_if, pick_if, arb, force_if;
  logic if_done, dm_done, dm_load_done, busy_if, busy_dm;

  assign elig_if      = if_req & ~halted;
  assign pick_if      = elig_if & (~dm_req | force_if);
  assign arb          = (state_q == ST_IDLE) & (elig_if | dm_req);
  assign if_done      = rvalid_q & (sel_q == SEL_IF);
  assign dm_done      = rvalid_q & (sel_q == SEL_DM);
  assign dm_load_done = dm_done & ~acc_we_q;
  assign busy_if      = (state_q == ST_ACCESS) & (sel_q == SEL_IF);
  assign busy_dm      = (state_q == ST_ACCESS) & (sel_q == SEL_DM);

  mips_starve_ctr #(.MAX_STARVE(MAX_STARVE)) u_starve (
    .clk      (clk),
    .rst_n    (rst_n),
    .inc      (arb & ~pick_if & elig_if),
    .clr      (arb & pick_if),
    .force_if (force_if)
  );

  always_comb begin
    state_d     = state_q;
    sel_d       = sel_q;
    lat_d       = lat_q;
    gnt_d       = 1'b0;
    mem_en_d    = 1'b0;
    mem_we_d    = 1'b0;
    acc_we_d    = acc_we_q;
    rvalid_d    = 1'b0;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    if_rdata_d  = if_rdata_q;
    dm_rdata_d  = dm_rdata_q;

    if (state_q == ST_IDLE) begin
      if (arb) begin
        state_d    = ST_ACCESS;
        lat_d      = CNT_W'(1);
        sel_d      = pick_if ? SEL_IF : SEL_DM;
        gnt_d      = 1'b1;
        mem_en_d   = 1'b1;
        mem_we_d   = ~pick_if & dm_we;
        acc_we_d   = ~pick_if & dm_we;
        mem_addr_d = pick_if ? if_addr : dm_addr;
        if (~pick_if & dm_we) begin
          mem_wdata_d = dm_wdata;
        end
      end
    end else if (lat_q == LAT_C) begin
      state_d  = ST_IDLE;
      rvalid_d = 1'b1;
    end else begin
      lat_d = lat_q + 1'b1;
    end

    // Read data is only on mem_rdata during the rvalid cycle; keep a copy for later.
    if (if_done) begin
      if_rdata_d = mem_rdata;
    end
    if (dm_load_done) begin
      dm_rdata_d = mem_rdata;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      sel_q       <= SEL_IF;
      lat_q       <= '0;
      gnt_q       <= 1'b0;
      mem_en_q    <= 1'b0;
      mem_we_q    <= 1'b0;
      acc_we_q    <= 1'b0;
      rvalid_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      if_rdata_q  <= '0;
      dm_rdata_q  <= '0;
    end else begin
      state_q     <= state_d;
      sel_q       <= sel_d;
      lat_q       <= lat_d;
      gnt_q       <= gnt_d;
      mem_en_q    <= mem_en_d;
      mem_we_q    <= mem_we_d;
      acc_we_q    <= acc_we_d;
      rvalid_q    <= rvalid_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      if_rdata_q  <= if_rdata_d;
      dm_rdata_q  <= dm_rdata_d;
    end
  end

  assign if_gnt    = gnt_q & (sel_q == SEL_IF);
  assign dm_gnt    = gnt_q & (sel_q == SEL_DM);
  assign if_rvalid = if_done;
  assign dm_rvalid = dm_done;
  assign if_rdata  = if_done ? mem_rdata : if_rdata_q;
  assign dm_rdata  = dm_load_done ? mem_rdata : dm_rdata_q;
  assign mem_en    = mem_en_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign stall_if  = (elig_if | busy_if) & ~if_done;
  assign stall_mem = (dm_req | busy_dm) & ~dm_done;

endmodule

// File: tb/tb_mips_mem_arbiter.sv
// Two arbiters (LAT=1 and LAT=4) against a transaction-level model of slot scheduling,
// plus directed scenarios with hand-computed cycle stamps and data.
module tb_mips_mem_arbiter;

  localparam int AW   = 10;
  localparam int DW   = 32;
  localparam int MAXS = 2;
  localparam int DEPTH = 1 << AW;

  function automatic logic [DW-1:0] init_word(input int i);
    if (i == 0) return 32'h2801000a;
    if (i == 8) return 32'hfc000000;
    return 32'h1000_0000 + DW'(i);
  endfunction

  function automatic int lat_of(input int k);
    return (k == 0) ? 1 : 4;
  endfunction

  logic clk = 1'b1;
  always #5 clk = ~clk;

  logic [1:0] rst_n, halted, if_req, dm_req, dm_we;
  logic [1:0] if_gnt, if_rvalid, dm_gnt, dm_rvalid, mem_en, mem_we, stall_if, stall_mem;
  logic [1:0][AW-1:0] if_addr, dm_addr, mem_addr;
  logic [1:0][DW-1:0] dm_wdata, if_rdata, dm_rdata, mem_wdata, mem_rdata;

  for (genvar k = 0; k < 2; k++) begin : g_inst
    localparam int L = (k == 0) ? 1 : 4;
    logic [DW-1:0] mem [DEPTH];
    logic [DW-1:0] pipe [4];

    mips_mem_arbiter #(.DW(DW), .AW(AW), .LAT(L), .MAX_STARVE(MAXS)) dut (
      .clk(clk), .rst_n(rst_n[k]), .halted(halted[k]),
      .if_req(if_req[k]), .if_addr(if_addr[k]), .if_gnt(if_gnt[k]),
      .if_rvalid(if_rvalid[k]), .if_rdata(if_rdata[k]),
      .dm_req(dm_req[k]), .dm_we(dm_we[k]), .dm_addr(dm_addr[k]), .dm_wdata(dm_wdata[k]),
      .dm_gnt(dm_gnt[k]), .dm_rvalid(dm_rvalid[k]), .dm_rdata(dm_rdata[k]),
      .mem_en(mem_en[k]), .mem_we(mem_we[k]), .mem_addr(mem_addr[k]),
      .mem_wdata(mem_wdata[k]), .mem_rdata(mem_rdata[k]),
      .stall_if(stall_if[k]), .stall_mem(stall_mem[k])
    );

    initial begin
      for (int i = 0; i < DEPTH; i++) mem[i] = init_word(i);
    end

    // Memory with an L-deep read pipeline; non-read slots carry a poison word.
    always @(posedge clk) begin
      pipe[0] <= (mem_en[k] && !mem_we[k]) ? mem[mem_addr[k]] : 32'hdeadbeef;
      for (int j = 1; j < 4; j++) pipe[j] <= pipe[j-1];
      if (mem_en[k] && mem_we[k]) mem[mem_addr[k]] = mem_wdata[k];
    end
    assign mem_rdata[k] = pipe[L-1];
  end

  int total, bad, cyc;
  int g_c[2], r_c[2], free_c[2], starve[2];
  logic m_sel_if[2], m_we[2];
  logic [AW-1:0] m_addr[2];
  logic [DW-1:0] m_wd[2], pend[2], e_ifd[2], e_dmd[2];
  logic [DW-1:0] ref_mem[2][DEPTH];
  int if_gnt_at[2], if_rv_at[2], dm_gnt_at[2], dm_rv_at[2], if_gnt_n[2];
  logic [DW-1:0] if_rv_dat[2], dm_rv_dat[2];
  logic seen_if_gnt[2], seen_dm_gnt[2];
  logic order_q[$];
  logic hold_if, hold_dm;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s cyc=%0d: got %h, want %h", nm, cyc, act, exp);
    end
  endtask

  task automatic chk1(input string nm, input logic act, input logic exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s cyc=%0d: got %b, want %b", nm, cyc, act, exp);
    end
  endtask

  // Slot model: an access won in cycle c is granted in c+1, returns in c+1+LAT,
  // and the next contest may happen in that return cycle.
  task automatic model_check();
    for (int k = 0; k < 2; k++) begin
      logic eg, eig, edg, eir, edr, bif, bdm, eif, edm, pif;
      if (!rst_n[k]) begin
        g_c[k] = -100; r_c[k] = -100; free_c[k] = 0; starve[k] = 0;
        e_ifd[k] = '0; e_dmd[k] = '0; m_sel_if[k] = 1'b0; m_we[k] = 1'b0;
        chk($sformatf("rst_mem_addr%0d", k), 32'(mem_addr[k]), 32'h0);
        chk($sformatf("rst_mem_wdata%0d", k), mem_wdata[k], 32'h0);
      end
      eg  = (cyc == g_c[k]);
      eig = eg && m_sel_if[k];
      edg = eg && !m_sel_if[k];
      eir = (cyc == r_c[k]) && m_sel_if[k];
      edr = (cyc == r_c[k]) && !m_sel_if[k];
      if (eir) e_ifd[k] = pend[k];
      if (edr && !m_we[k]) e_dmd[k] = pend[k];
      bif = m_sel_if[k] && cyc >= g_c[k] && cyc < r_c[k];
      bdm = !m_sel_if[k] && cyc >= g_c[k] && cyc < r_c[k];
      chk1($sformatf("if_gnt%0d", k), if_gnt[k], eig);
      chk1($sformatf("dm_gnt%0d", k), dm_gnt[k], edg);
      chk1($sformatf("mem_en%0d", k), mem_en[k], eg);
      chk1($sformatf("mem_we%0d", k), mem_we[k], eg && m_we[k]);
      chk1($sformatf("if_rvalid%0d", k), if_rvalid[k], eir);
      chk1($sformatf("dm_rvalid%0d", k), dm_rvalid[k], edr);
      chk($sformatf("if_rdata%0d", k), if_rdata[k], e_ifd[k]);
      chk($sformatf("dm_rdata%0d", k), dm_rdata[k], e_dmd[k]);
      chk1($sformatf("stall_if%0d", k), stall_if[k], ((if_req[k] & ~halted[k]) | bif) & ~eir);
      chk1($sformatf("stall_mem%0d", k), stall_mem[k], (dm_req[k] | bdm) & ~edr);
      if (eg) chk($sformatf("mem_addr%0d", k), 32'(mem_addr[k]), 32'(m_addr[k]));
      if (eg && m_we[k]) chk($sformatf("mem_wdata%0d", k), mem_wdata[k], m_wd[k]);

      seen_if_gnt[k] = if_gnt[k];
      seen_dm_gnt[k] = dm_gnt[k];
      if (if_gnt[k]) begin if_gnt_at[k] = cyc; if_gnt_n[k]++; end
      if (dm_gnt[k]) dm_gnt_at[k] = cyc;
      if (if_rvalid[k]) begin if_rv_at[k] = cyc; if_rv_dat[k] = if_rdata[k]; end
      if (dm_rvalid[k]) begin dm_rv_at[k] = cyc; dm_rv_dat[k] = dm_rdata[k]; end
      if (k == 0 && (if_gnt[k] || dm_gnt[k])) order_q.push_back(if_gnt[k]);

      eif = if_req[k] & ~halted[k];
      edm = dm_req[k];
      if (rst_n[k] && cyc >= free_c[k] && (eif || edm)) begin
        pif = eif && (!edm || starve[k] >= MAXS);
        if (pif) starve[k] = 0;
        else if (eif && starve[k] < MAXS) starve[k]++;
        g_c[k] = cyc + 1;
        r_c[k] = cyc + 1 + lat_of(k);
        free_c[k] = r_c[k];
        m_sel_if[k] = pif;
        m_we[k] = !pif && dm_we[k];
        m_addr[k] = pif ? if_addr[k] : dm_addr[k];
        m_wd[k] = dm_wdata[k];
        if (m_we[k]) ref_mem[k][m_addr[k]] = m_wd[k];
        else pend[k] = ref_mem[k][m_addr[k]];
      end
    end
  endtask

  task automatic step();
    @(negedge clk);
    model_check();
    @(posedge clk);
    #1;
    cyc++;
    for (int k = 0; k < 2; k++) begin
      if ((k != 0 || !hold_if) && seen_if_gnt[k]) if_req[k] = 1'b0;
      if ((k != 0 || !hold_dm) && seen_dm_gnt[k]) dm_req[k] = 1'b0;
    end
  endtask

  initial begin
    int t0, t1, th, n0;
    total = 0; bad = 0; cyc = 0;
    rst_n = '0; halted = '0; if_req = '0; dm_req = '0; dm_we = '0;
    if_addr = '0; dm_addr = '0; dm_wdata = '0;
    hold_if = 1'b0; hold_dm = 1'b0;
    for (int k = 0; k < 2; k++) begin
      for (int i = 0; i < DEPTH; i++) ref_mem[k][i] = init_word(i);
      if_gnt_at[k] = -1; if_rv_at[k] = -1; dm_gnt_at[k] = -1; dm_rv_at[k] = -1;
      if_gnt_n[k] = 0; seen_if_gnt[k] = 1'b0; seen_dm_gnt[k] = 1'b0;
      g_c[k] = -100; r_c[k] = -100; free_c[k] = 0; starve[k] = 0;
    end
    repeat (3) step();
    rst_n = 2'b11;
    repeat (2) step();

    // Fetch only
    t0 = cyc; if_addr[0] = 10'd0; if_req[0] = 1'b1;
    repeat (5) step();
    chk("t1_if_gnt_cyc", if_gnt_at[0], t0 + 1);
    chk("t1_if_rv_cyc", if_rv_at[0], t0 + 2);
    chk("t1_if_rdata", if_rv_dat[0], 32'h2801000a);

    // Collision: data first, fetch next slot
    t0 = cyc; if_addr[0] = 10'd5; if_req[0] = 1'b1;
    dm_addr[0] = 10'd8; dm_we[0] = 1'b0; dm_req[0] = 1'b1;
    repeat (6) step();
    chk("t2_dm_gnt_cyc", dm_gnt_at[0], t0 + 1);
    chk("t2_dm_rv_cyc", dm_rv_at[0], t0 + 2);
    chk("t2_dm_rdata", dm_rv_dat[0], 32'hfc000000);
    chk("t2_if_gnt_cyc", if_gnt_at[0], t0 + 3);
    chk("t2_if_rv_cyc", if_rv_at[0], t0 + 4);
    chk("t2_if_rdata", if_rv_dat[0], 32'h10000005);

    // Starvation: both requesters always asking
    order_q.delete();
    hold_if = 1'b1; hold_dm = 1'b1;
    if_addr[0] = 10'd0; dm_addr[0] = 10'd8; if_req[0] = 1'b1; dm_req[0] = 1'b1;
    repeat (12) step();
    if_req[0] = 1'b0; dm_req[0] = 1'b0; hold_if = 1'b0; hold_dm = 1'b0;
    repeat (4) step();
    for (int i = 0; i < 6; i++)
      chk1($sformatf("t3_grant%0d_is_fetch", i), (i < order_q.size()) ? order_q[i] : 1'bx, (i % 3) == 2);

    // Store then load back
    t0 = cyc; dm_we[0] = 1'b1; dm_addr[0] = 10'd20; dm_wdata[0] = 32'h0000001e; dm_req[0] = 1'b1;
    repeat (3) step();
    chk("t4_st_gnt_cyc", dm_gnt_at[0], t0 + 1);
    chk("t4_st_ack_cyc", dm_rv_at[0], t0 + 2);
    chk("t4_st_rdata_kept", dm_rv_dat[0], 32'hfc000000);
    t1 = cyc; dm_we[0] = 1'b0; dm_req[0] = 1'b1;
    repeat (3) step();
    chk("t4_ld_rv_cyc", dm_rv_at[0], t1 + 2);
    chk("t4_ld_rdata", dm_rv_dat[0], 32'h0000001e);

    // Halt masks fetch; data still served; unhalt during a data access
    n0 = if_gnt_n[0];
    t0 = cyc; halted[0] = 1'b1; if_addr[0] = 10'd3; if_req[0] = 1'b1;
    repeat (2) step();
    dm_addr[0] = 10'd8; dm_req[0] = 1'b1;
    repeat (7) step();
    dm_addr[0] = 10'd20; dm_req[0] = 1'b1;
    step();
    halted[0] = 1'b0; th = cyc;
    repeat (4) step();
    chk("t5_dm_rv_cyc", dm_rv_at[0], t0 + 11);
    chk("t5_dm_rdata", dm_rv_dat[0], 32'h0000001e);
    chk("t5_if_gnt_count", if_gnt_n[0] - n0, 1);
    chk("t5_if_gnt_cyc", if_gnt_at[0], th + 2);
    chk("t5_if_rdata", if_rv_dat[0], 32'h10000003);

    // Reset in the second access cycle of a LAT=4 fetch
    t0 = cyc; if_addr[1] = 10'd0; if_req[1] = 1'b1;
    repeat (2) step();
    rst_n[1] = 1'b0;
    #1;
    chk1("t6_stall_if_async", stall_if[1], 1'b0);
    chk("t6_if_gnt_cyc", if_gnt_at[1], t0 + 1);
    repeat (2) step();
    rst_n[1] = 1'b1;
    repeat (8) step();
    chk("t6_no_rvalid", if_rv_at[1], 32'hffffffff);
    t1 = cyc; if_addr[1] = 10'd8; if_req[1] = 1'b1;
    repeat (7) step();
    chk("t6_if_gnt_cyc2", if_gnt_at[1], t1 + 1);
    chk("t6_if_rv_cyc", if_rv_at[1], t1 + 5);
    chk("t6_if_rdata", if_rv_dat[1], 32'hfc000000);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
